// File: rtl/pool_ibuf_ctrl.sv
// pool_ibuf_ctrl: upstream control for the max-pool layer.
// Accepts a raster-order pixel stream (all channels per beat), writes each
// beat into the per-channel window buffers, and pulses o_func_start whenever
// a complete stride-aligned kernel window is resident. Stalls the stream
// while the downstream stage reports busy.
// Optional: define POOL_IBUF_CTRL_WIN_IDX_EN to add o_win_idx, the row-major
// index of the window whose o_func_start is pending or asserted.
module pool_ibuf_ctrl #(
    parameter int unsigned input_channels = 256,
    parameter int unsigned img_width      = 13,
    parameter int unsigned kernel_dim     = 3,
    parameter int unsigned stride         = 2,
    parameter int unsigned datatype_size  = 4
`ifdef POOL_IBUF_CTRL_WIN_IDX_EN
    ,
    localparam int unsigned win_per_axis = (img_width - kernel_dim) / stride + 1,
    localparam int unsigned win_total    = win_per_axis * win_per_axis,
    localparam int unsigned win_idx_w    = (win_total > 1) ? $clog2(win_total) : 1
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_data_valid,
    input  logic [datatype_size-1:0] i_data [input_channels],
    output logic                     o_data_ready,
    output logic                     o_ibuf_we [input_channels],
    output logic [datatype_size-1:0] o_ibuf_wr_data [input_channels],
    output logic                     o_func_start,
    input  logic                     i_next_busy,
    output logic                     o_done
`ifdef POOL_IBUF_CTRL_WIN_IDX_EN
    ,
    output logic [win_idx_w-1:0]     o_win_idx
`endif
);

    localparam int unsigned pos_w = $clog2(img_width + 1);
    localparam int unsigned ph_w  = (stride > 1) ? $clog2(stride) : 1;

    localparam logic [pos_w-1:0] last_pos = pos_w'(img_width - 1);
    localparam logic [pos_w-1:0] k_m1     = pos_w'(kernel_dim - 1);
    localparam logic [ph_w-1:0]  ph_last  = ph_w'(stride - 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WRITE,
        EMIT,
        DONE
    } state_t;

    state_t           state;
    logic [pos_w-1:0] row;
    logic [pos_w-1:0] col;
    logic [ph_w-1:0]  row_ph;
    logic [ph_w-1:0]  col_ph;
    logic             we_r;
    logic             win_pend;
    logic             last_pend;
    logic             win_hit;
    logic             is_last;

    // Classify the pixel currently addressed by the row/col counters.
    always_comb begin
        win_hit = (row >= k_m1) && (col >= k_m1) && (row_ph == '0) && (col_ph == '0);
        is_last = (row == last_pos) && (col == last_pos);
    end

    // Every channel's write enable follows the single registered strobe.
    always_comb begin
        for (int unsigned k = 0; k < input_channels; k++) begin
            o_ibuf_we[k] = we_r;
        end
    end

    // Control FSM: position/phase counters and all registered outputs.
    // Phase counters only start counting once the axis reaches kernel_dim-1,
    // so phase 0 marks stride alignment without a modulo operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            row_ph         <= '0;
            col_ph         <= '0;
            we_r           <= 1'b0;
            win_pend       <= 1'b0;
            last_pend      <= 1'b0;
            o_data_ready   <= 1'b0;
            o_ibuf_wr_data <= '{default: '0};
            o_func_start   <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            we_r         <= 1'b0;
            o_func_start <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                IDLE: begin
                    row    <= '0;
                    col    <= '0;
                    row_ph <= '0;
                    col_ph <= '0;
                    if (i_start) begin
                        state        <= STREAM;
                        o_data_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (i_data_valid && o_data_ready) begin
                        o_ibuf_wr_data <= i_data;
                        we_r           <= 1'b1;
                        win_pend       <= win_hit;
                        last_pend      <= is_last;
                        if (col == last_pos) begin
                            col    <= '0;
                            col_ph <= '0;
                            row    <= row + 1'b1;
                            if (row >= k_m1) begin
                                row_ph <= (row_ph == ph_last) ? '0 : row_ph + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                            if (col >= k_m1) begin
                                col_ph <= (col_ph == ph_last) ? '0 : col_ph + 1'b1;
                            end
                        end
                        if (win_hit || is_last) begin
                            state        <= WRITE;
                            o_data_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    state <= win_pend ? EMIT : DONE;
                end
                EMIT: begin
                    if (!i_next_busy) begin
                        o_func_start <= 1'b1;
                        if (last_pend) begin
                            state <= DONE;
                        end else begin
                            state        <= STREAM;
                            o_data_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                    row    <= '0;
                    col    <= '0;
                    row_ph <= '0;
                    col_ph <= '0;
                end
                default: begin
                    state        <= IDLE;
                    o_data_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef POOL_IBUF_CTRL_WIN_IDX_EN
    // Window index advances after each emitted window and rests at 0 in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_win_idx <= '0;
        end else if (state == IDLE) begin
            o_win_idx <= '0;
        end else if (o_func_start) begin
            o_win_idx <= o_win_idx + 1'b1;
        end
    end
`endif

endmodule
